flex_down_counter: RTL
======================

# flex_down_counter

Parameterized loadable down-counter/timer, the counterpart to the team's rollover up-counter. The up-counter counts events up to a limit; this block is loaded with a tick budget and counts it down to zero. It signals the terminal count with a registered level flag and a single-cycle done pulse. It sits in the Cartoonifier control path to time fixed-length operations such as SRAM access windows, line blanking and per-pixel filter stages.

## Interface
- NUM_CNT_BITS, default 4: width of the counter, the load value and the reload register.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous clear; highest priority after reset.
- load  in  1  single-cycle strobe that captures load_val and starts a countdown.
- load_val  in  NUM_CNT_BITS  countdown start value, sampled only when load=1.
- count_enable  in  1  tick qualifier; the count decrements only when this is 1.
- count_out  out  NUM_CNT_BITS  current count, registered.
- busy  out  1  1 while in RUN, registered.
- zero_flag  out  1  level, 1 whenever count_out==0 after a countdown completes; registered.
- done  out  1  single-cycle pulse on the edge where count_out reaches 0; registered.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE with count_out=0, busy=0, zero_flag=0, done=0 and reload register=0.
- Priority per edge: rst, then clear, then load, then count_enable.
- clear in any state: count_out=0, state=IDLE, zero_flag=0, done=0, busy=0. The reload register is unchanged.
- load in any state: reload register ← load_val and count_out ← load_val.
  - If load_val≠0: enter RUN, zero_flag=0.
  - If load_val=0: enter DONE, zero_flag=1, done=1.
  - A load during RUN restarts the countdown; no done pulse is produced for the aborted run.
- IDLE: count_enable is ignored and count_out holds.
- RUN with count_enable=1: count_out ← count_out−1.
  - If the new value is 0: enter DONE, zero_flag=1, done=1 on that same edge.
- RUN with count_enable=0: everything holds. done is 0 on every edge where it is not explicitly set.
- DONE: count_out holds 0 and zero_flag holds 1 until a clear, a load or an auto-reload (see Configuration).
- Arithmetic is unsigned, NUM_CNT_BITS wide. The counter never decrements below 0, so it never wraps. load_val=2^NUM_CNT_BITS−1 is legal.
- A reset asserted mid-run returns the block to reset values immediately, with no done pulse.

## Timing
- Every output is a flop; there are no combinational paths from input to output.
- Load latency: with load at edge k, count_out=load_val and busy=1 are visible after edge k.
- Countdown: a load of N followed by continuous count_enable asserts done and zero_flag after the N-th enabled edge.
- done is exactly one cycle wide, even if count_enable stays high in DONE (without auto-reload).
- load and count_enable together on one edge: the load wins and that tick is not counted.

## Configuration
- Macro FLEX_DOWN_AUTO_RELOAD_EN.
- Defined: in DONE, an edge with count_enable=1 reloads count_out from the reload register, clears zero_flag and re-enters RUN.
  - If the reload register is 0, the block instead stays in DONE and pulses done again.
  - The periodic done interval is therefore load_val+1 enabled ticks.
- Undefined: DONE is terminal until clear or load, and count_enable is ignored in DONE.

## Test plan
- Reset, then load=1 with load_val=5, then 5 cycles of count_enable=1.
  - Required: count_out steps 5,4,3,2,1,0, and done=1 only on the edge reaching 0.
  - After that: zero_flag=1, busy=0.
- load_val=3, with count_enable toggled 1,0,1,0,1.
  - Required: count_out reaches 0 only after the 3rd enabled edge; the disabled cycles hold the value.
- load_val=0.
  - Required: next edge gives DONE, zero_flag=1, done=1 for 1 cycle, busy=0.
- Mid-run restart: load 6, tick twice (count_out=4), then load=1 with load_val=2 and count_enable=1 on the same edge.
  - Required: count_out=2, no done pulse, and 2 more ticks reach 0.
- Clear and reset priority: with count_out=3 in RUN, assert clear and load together.
  - Required: count_out=0, IDLE, zero_flag=0.
  - Also: asserting rst mid-run gives all outputs 0 immediately, asynchronously.
- FLEX_DOWN_AUTO_RELOAD_EN defined, load_val=2, continuous count_enable.
  - Required: count_out sequence 2,1,0,2,1,0…, with done on every edge reaching 0 (period 3).
  - Undefined build: count_out stays at 0 and only one done pulse occurs.

Source files
------------

// File: rtl/flex_down_counter.sv
// rtl/flex_down_counter.sv - loadable down-counter/timer with terminal-count flag and done pulse
// Optional macro FLEX_DOWN_AUTO_RELOAD_EN: periodic reload from the reload register in DONE.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    zero_flag,
    output logic                    done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    zero_q, zero_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
            zero_d  = 1'b0;
        end else if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            if (load_val != CNT_ZERO) begin
                state_d = RUN;
                zero_d  = 1'b0;
            end else begin
                state_d = DONE;
                zero_d  = 1'b1;
                done_d  = 1'b1;
            end
        end else if (count_enable) begin
            case (state_q)
                RUN: begin
                    // RUN is only entered with a non-zero count, so this never wraps
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_d = DONE;
                        zero_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
`ifdef FLEX_DOWN_AUTO_RELOAD_EN
                DONE: begin
                    if (reload_q != CNT_ZERO) begin
                        state_d = RUN;
                        count_d = reload_q;
                        zero_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
`else
                DONE: begin
                end
`endif
                IDLE: begin
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                    zero_d  = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    assign count_out = count_q;
    assign busy      = busy_q;
    assign zero_flag = zero_q;
    assign done      = done_q;
endmodule
